// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared arbiter state type, control-word bit indices and RAM depth
// VERIFY state exists only when RAM_ARB_READBACK_EN is defined
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_CPU,
    ST_DRAIN,
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE
`ifdef RAM_ARB_READBACK_EN
    , ST_VERIFY
`endif
  } arb_state_t;

  localparam int CW_NLMA = 11;
  localparam int CW_NLMD = 10;
  localparam int CW_NCE  = 9;
  localparam int CW_NLR  = 8;

  localparam int RAM_DEPTH = 16;

  // Active-low RAM-side strobes the loader asserts while sitting in state s
  function automatic logic [CW_NLMA:CW_NLR] loader_ctl(input arb_state_t s);
    logic [CW_NLMA:CW_NLR] cw;
    cw = '1;
    case (s)
      ST_ADDR:  cw[CW_NLMA] = 1'b0;
      ST_DATA:  cw[CW_NLMD] = 1'b0;
      ST_WRITE: begin
        cw[CW_NCE] = 1'b0;
        cw[CW_NLR] = 1'b0;
      end
`ifdef RAM_ARB_READBACK_EN
      ST_VERIFY: cw[CW_NCE] = 1'b0;
`endif
      default: cw = '1;
    endcase
    return cw;
  endfunction

  function automatic logic is_busy(input arb_state_t s);
    return (s == ST_ADDR) || (s == ST_DATA) || (s == ST_WRITE)
`ifdef RAM_ARB_READBACK_EN
        || (s == ST_VERIFY)
`endif
        ;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop pin synchronizer with single-cycle rising-edge pulse
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - hands program RAM/MAR between CPU control path and pin byte-loader
// Optional post-write readback compare: RAM_ARB_READBACK_EN
module ram_access_arbiter #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_req,
  input  logic              prog_strobe,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              cpu_boundary,
  input  logic              cpu_nLma,
  input  logic              cpu_nLmd,
  input  logic              cpu_nCE,
  input  logic              cpu_nLr,
  output logic              mem_nLma,
  output logic              mem_nLmd,
  output logic              mem_nCE,
  output logic              mem_nLr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              cpu_hold,
  output logic              prog_busy,
  output logic              prog_overrun,
  output logic              verify_err,
  output logic [ADDR_W:0]   write_count
);
  import cpu_pkg::*;

  localparam logic [ADDR_W:0] W_FULL = (ADDR_W+1)'(RAM_DEPTH);

  logic                  w_req;
  logic                  w_req_rise_unused;
  logic                  w_stb_sync_unused;
  logic                  w_stb_rise;
  arb_state_t            r_state;
  arb_state_t            w_next;
  logic                  r_pass;
  logic [CW_NLMA:CW_NLR] r_cw;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_W-1:0]     r_bus;
  logic                  r_oe;
  logic                  r_hold;
  logic                  r_busy;
  logic                  r_overrun;
  logic [ADDR_W:0]       r_wcount;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk(clk), .rst_n(rst_n), .i_async(prog_req),
    .o_sync(w_req), .o_rise(w_req_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stb (
    .clk(clk), .rst_n(rst_n), .i_async(prog_strobe),
    .o_sync(w_stb_sync_unused), .o_rise(w_stb_rise)
  );

  // A req drop never interrupts ADDR..WRITE; it is only honoured in DRAIN/IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CPU:   if (w_req) w_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!w_req)            w_next = ST_CPU;
        else if (cpu_boundary) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!w_req)          w_next = ST_CPU;
        else if (w_stb_rise) w_next = ST_ADDR;
      end
      ST_ADDR:   w_next = ST_DATA;
      ST_DATA:   w_next = ST_WRITE;
`ifdef RAM_ARB_READBACK_EN
      ST_WRITE:  w_next = ST_VERIFY;
      ST_VERIFY: w_next = ST_IDLE;
`else
      ST_WRITE:  w_next = ST_IDLE;
`endif
      default:   w_next = ST_CPU;
    endcase
  end

`ifdef RAM_ARB_READBACK_EN
  logic r_verr;
  assign verify_err = r_verr;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^ram_rdata;
  assign verify_err     = 1'b0;
`endif

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CPU;
      r_pass    <= 1'b1;
      r_cw      <= '1;
      r_data    <= '0;
      r_bus     <= '0;
      r_oe      <= 1'b0;
      r_hold    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_wcount  <= '0;
`ifdef RAM_ARB_READBACK_EN
      r_verr    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_pass  <= (w_next == ST_CPU) || (w_next == ST_DRAIN);
      r_hold  <= !((w_next == ST_CPU) || (w_next == ST_DRAIN));
      r_busy  <= is_busy(w_next);
      r_cw    <= loader_ctl(w_next);
      r_oe    <= (w_next == ST_ADDR) || (w_next == ST_DATA);
      case (w_next)
        ST_ADDR: r_bus <= {{(DATA_W-ADDR_W){1'b0}}, prog_addr};
        ST_DATA: r_bus <= r_data;
        default: r_bus <= '0;
      endcase
      if (r_state == ST_IDLE && w_next == ST_ADDR) r_data <= prog_data;
      if (w_next == ST_CPU) begin
        r_overrun <= 1'b0;
        r_wcount  <= '0;
`ifdef RAM_ARB_READBACK_EN
        r_verr    <= 1'b0;
`endif
      end else begin
        if (w_stb_rise && r_busy) r_overrun <= 1'b1;
        if (r_state == ST_WRITE && r_wcount != W_FULL) r_wcount <= r_wcount + 1'b1;
`ifdef RAM_ARB_READBACK_EN
        if (r_state == ST_VERIFY && ram_rdata != r_data) r_verr <= 1'b1;
`endif
      end
    end
  end

  assign mem_nLma     = r_pass ? cpu_nLma : r_cw[CW_NLMA];
  assign mem_nLmd     = r_pass ? cpu_nLmd : r_cw[CW_NLMD];
  assign mem_nCE      = r_pass ? cpu_nCE  : r_cw[CW_NCE];
  assign mem_nLr      = r_pass ? cpu_nLr  : r_cw[CW_NLR];
  assign bus_out      = r_bus;
  assign bus_oe       = r_oe;
  assign cpu_hold     = r_hold;
  assign prog_busy    = r_busy;
  assign prog_overrun = r_overrun;
  assign write_count  = r_wcount;

endmodule
